// File: rtl/alu_funct_pkg.sv
// rtl/alu_funct_pkg.sv - ALU funct codes and issue-sequencer state encoding
package alu_funct_pkg;

  localparam logic [5:0] FN_IDLE = 6'd0;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_DIVU = 6'd27;
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_DIV_RUN,
    S_DIV_SETTLE,
    S_RD_HI,
    S_RD_LO,
    S_RESP
  } seq_state_t;

  function automatic logic is_single_op(input logic [5:0] funct);
    return (funct == FN_AND) || (funct == FN_OR)  || (funct == FN_ADD) ||
           (funct == FN_SUB) || (funct == FN_SLT) || (funct == FN_SRL);
  endfunction

endpackage

// File: rtl/issue_timer.sv
// rtl/issue_timer.sv - loadable down-counter that paces each sequencer state
module issue_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Saturates at zero so a state that never reloads simply sits expired.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - request sequencer driving the MIPS-funct ALU operands and Signal
module alu_issue_seq
  import alu_funct_pkg::*;
#(
  parameter int ALU_LAT    = 1,
  parameter int DIV_CYCLES = 33,
  parameter int HILO_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [5:0]  Signal,
  input  logic [31:0] aluOut,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_hi,
  output logic        rsp_err
);

  localparam int MAX_A   = (DIV_CYCLES > HILO_LAT) ? DIV_CYCLES : HILO_LAT;
  localparam int MAX_CNT = (MAX_A > ALU_LAT) ? MAX_A : ALU_LAT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] LD_ALU  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] LD_DIV  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HILO = CNT_W'(HILO_LAT - 1);

  seq_state_t  state_q, state_d;
  logic [31:0] data_a_q, data_a_d;
  logic [31:0] data_b_q, data_b_d;
  logic [5:0]  signal_q, signal_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] rsp_hi_q, rsp_hi_d;
  logic        rsp_err_q, rsp_err_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  issue_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_a_q   <= '0;
      data_b_q   <= '0;
      signal_q   <= FN_IDLE;
      rsp_data_q <= '0;
      rsp_hi_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      signal_q   <= signal_d;
      rsp_data_q <= rsp_data_d;
      rsp_hi_q   <= rsp_hi_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Signal is registered, so its next value is decided alongside the state.
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    signal_d   = signal_q;
    rsp_data_d = rsp_data_q;
    rsp_hi_d   = rsp_hi_q;
    rsp_err_d  = rsp_err_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          data_a_d   = req_a;
          data_b_d   = req_b;
          rsp_data_d = '0;
          rsp_hi_d   = '0;
          rsp_err_d  = 1'b0;
          tmr_load   = 1'b1;
          if (is_single_op(req_funct)) begin
            state_d   = S_EXEC;
            signal_d  = req_funct;
            tmr_value = LD_ALU;
          end else if (req_funct == FN_DIVU && req_b != '0) begin
            state_d   = S_DIV_RUN;
            signal_d  = FN_DIVU;
            tmr_value = LD_DIV;
          end else begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (tmr_zero) begin
          state_d    = S_RESP;
          signal_d   = FN_IDLE;
          rsp_data_d = aluOut;
          rsp_hi_d   = '0;
          tmr_load   = 1'b1;
        end
      end
      S_DIV_RUN: begin
        if (tmr_zero) begin
          state_d   = S_DIV_SETTLE;
          signal_d  = FN_IDLE;
          tmr_load  = 1'b1;
          tmr_value = LD_HILO;
        end
      end
      S_DIV_SETTLE: begin
        if (tmr_zero) begin
          state_d   = S_RD_HI;
          signal_d  = FN_MFHI;
          tmr_load  = 1'b1;
          tmr_value = LD_ALU;
        end
      end
      S_RD_HI: begin
        if (tmr_zero) begin
          state_d   = S_RD_LO;
          signal_d  = FN_MFLO;
          rsp_hi_d  = aluOut;
          tmr_load  = 1'b1;
          tmr_value = LD_ALU;
        end
      end
      S_RD_LO: begin
        if (tmr_zero) begin
          state_d    = S_RESP;
          signal_d   = FN_IDLE;
          rsp_data_d = aluOut;
          tmr_load   = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d  = S_IDLE;
          tmr_load = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        signal_d = FN_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE) && !reset;
    rsp_valid = (state_q == S_RESP);
  end

  assign dataA    = data_a_q;
  assign dataB    = data_b_q;
  assign Signal   = signal_q;
  assign rsp_data = rsp_data_q;
  assign rsp_hi   = rsp_hi_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - self-checking bench for alu_issue_seq with a behavioural ALU
module tb_alu_issue_seq;

  localparam int ALU_LAT    = 1;
  localparam int DIV_CYCLES = 33;
  localparam int HILO_LAT   = 1;

  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_DIVU = 6'd27;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_funct = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic [31:0] aluOut;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data, rsp_hi;
  logic        rsp_err;

  alu_issue_seq #(.ALU_LAT(ALU_LAT), .DIV_CYCLES(DIV_CYCLES), .HILO_LAT(HILO_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_a(req_a), .req_b(req_b), .dataA(dataA), .dataB(dataB),
    .Signal(Signal), .aluOut(aluOut), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_hi(rsp_hi), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] alu_fn(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      F_SRL:   return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU: HI/LO written only after DIVU has been held the full divide time.
  logic [31:0] hi_r = '0;
  logic [31:0] lo_r = '0;
  int div_cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      hi_r <= '0; lo_r <= '0; div_cnt <= 0;
    end else if (Signal == F_DIVU) begin
      if (div_cnt == DIV_CYCLES - 1 && dataB != 0) begin
        hi_r <= dataA % dataB;
        lo_r <= dataA / dataB;
      end
      div_cnt <= div_cnt + 1;
    end else begin
      div_cnt <= 0;
    end
  end

  always_comb begin
    aluOut = '0;
    case (Signal)
      F_MFHI:  aluOut = hi_r;
      F_MFLO:  aluOut = lo_r;
      default: aluOut = alu_fn(Signal, dataA, dataB);
    endcase
  end

  // Transaction model: per-cycle Signal schedule plus the response it must produce.
  logic [5:0]  sig_q[$];
  logic        m_started = 1'b0;
  logic        m_idle = 1'b1;
  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0, m_hi = '0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1'b1;
      sig_q.delete();
      m_idle = 1'b1; m_valid = 1'b0; m_a = '0; m_b = '0;
    end else if (m_started) begin
      if (m_valid) begin
        if (rsp_ready) begin m_valid = 1'b0; m_idle = 1'b1; end
      end else if (sig_q.size() != 0) begin
        sig_q.delete(0);
        if (sig_q.size() == 0) m_valid = 1'b1;
      end else if (m_idle && req_valid) begin
        m_idle = 1'b0; m_a = req_a; m_b = req_b;
        m_data = '0; m_hi = '0; m_err = 1'b0;
        if (req_funct inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL}) begin
          for (int i = 0; i < ALU_LAT; i++) sig_q.push_back(req_funct);
          m_data = alu_fn(req_funct, req_a, req_b);
        end else if (req_funct == F_DIVU && req_b != 0) begin
          for (int i = 0; i < DIV_CYCLES; i++) sig_q.push_back(F_DIVU);
          for (int i = 0; i < HILO_LAT; i++) sig_q.push_back(6'd0);
          for (int i = 0; i < ALU_LAT; i++) sig_q.push_back(F_MFHI);
          for (int i = 0; i < ALU_LAT; i++) sig_q.push_back(F_MFLO);
          m_data = req_a / req_b;
          m_hi = req_a % req_b;
        end else begin
          m_err = 1'b1;
          m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("req_ready", 32'(req_ready), 32'(m_idle && !reset));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("Signal", 32'(Signal), 32'((sig_q.size() != 0) ? sig_q[0] : 6'd0));
      chk("dataA", dataA, m_a);
      chk("dataB", dataB, m_b);
      if (m_valid) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_hi", rsp_hi, m_hi);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  typedef struct {
    logic [31:0] d;
    logic [31:0] h;
    logic        e;
    int          c;
  } rsp_t;
  rsp_t got_q[$];

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) got_q.push_back('{rsp_data, rsp_hi, rsp_err, cyc});
  end

  int t_acc = 0;

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bit done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        t_acc = cyc + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      fail_now("issue_timeout");
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int n_before);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (got_q.size() > n_before) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) fail_now("rsp_timeout");
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic [31:0] exp_h, input logic exp_e, input int exp_lat);
    int n0;
    n0 = got_q.size();
    issue(f, a, b);
    wait_rsp(n0);
    if (got_q.size() > n0) begin
      chk({name, "_data"}, got_q[n0].d, exp_d);
      chk({name, "_hi"}, got_q[n0].h, exp_h);
      chk({name, "_err"}, 32'(got_q[n0].e), 32'(exp_e));
      chk({name, "_latency"}, 32'(got_q[n0].c - t_acc + 1), 32'(exp_lat));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int t2;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_Signal", 32'(Signal), 32'd0);
    chk("reset_dataA", dataA, 32'd0);
    chk("reset_dataB", dataB, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_hi", rsp_hi, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    run_op("add", F_ADD, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 2);
    run_op("and", F_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 32'd0, 1'b0, 2);
    run_op("or", F_OR, 32'hA000_0001, 32'h0500_0010, 32'hA500_0011, 32'd0, 1'b0, 2);
    run_op("srl", F_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd0, 1'b0, 2);

    n0 = got_q.size();
    issue(F_SUB, 32'd3, 32'd5);
    issue(F_SLT, 32'hFFFF_FFFF, 32'd1);
    t2 = t_acc;
    wait_rsp(n0 + 1);
    if (got_q.size() > n0 + 1) begin
      chk("sub_data", got_q[n0].d, 32'hFFFF_FFFE);
      chk("slt_data", got_q[n0 + 1].d, 32'd1);
      chk("slt_accept_after_rsp", 32'(t2), 32'(got_q[n0].c + 2));
    end

    run_op("divu", F_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 37);
    run_op("divu_b0", F_DIVU, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);
    run_op("bad_funct", 6'b000111, 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 1);

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n0 = got_q.size();
    issue(F_ADD, 32'd1, 32'd1);
    repeat (10) @(negedge clk);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_data", rsp_data, 32'd2);
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_rsp(n0);

    n0 = got_q.size();
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midreset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_Signal", 32'(Signal), 32'd0);
    chk("midreset_dataA", dataA, 32'd0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_req_ready_after", 32'(req_ready), 32'd1);
    repeat (45) @(negedge clk);
    chk("midreset_no_response", 32'(got_q.size()), 32'(n0));
    run_op("add_after_reset", F_ADD, 32'd2, 32'd2, 32'd4, 32'd0, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
